// File: rtl/gate_bist_pkg.sv
// Shared encodings for the gate BIST checker: FSM states, y bit positions, MISR helpers.
// The MISR helper is only referenced when GATE_BIST_SIGNATURE_EN is defined.
package gate_bist_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_APPLY = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Bit positions inside the packed gate output bus
    localparam int Y_AND  = 0;
    localparam int Y_OR   = 1;
    localparam int Y_NOT  = 2;
    localparam int Y_NAND = 3;
    localparam int Y_NOR  = 4;
    localparam int Y_XOR  = 5;
    localparam int Y_XNOR = 6;

    localparam logic [7:0] MISR_POLY  = 8'h71;
    localparam logic [7:0] SIG_GOLDEN = 8'hAD;

    typedef struct packed {
        logic [2:0] err_count;
        logic [1:0] fail_vec;
        logic [6:0] fail_bits;
    } bist_result_t;

    function automatic logic [7:0] misr_step(input logic [7:0] sig, input logic [6:0] y);
        return {sig[6:0], 1'b0} ^ (sig[7] ? MISR_POLY : 8'h00) ^ {1'b0, y};
    endfunction

endpackage

// File: rtl/gate_golden_model.sv
// Combinational reference for the basic-gate block: {a,b} -> expected packed y.
module gate_golden_model
    import gate_bist_pkg::*;
(
    input  logic       a_i,
    input  logic       b_i,
    output logic [6:0] y_o
);

    always_comb begin
        y_o         = '0;
        y_o[Y_AND]  = a_i & b_i;
        y_o[Y_OR]   = a_i | b_i;
        y_o[Y_NOT]  = ~a_i;
        y_o[Y_NAND] = ~(a_i & b_i);
        y_o[Y_NOR]  = ~(a_i | b_i);
        y_o[Y_XOR]  = a_i ^ b_i;
        y_o[Y_XNOR] = ~(a_i ^ b_i);
    end

endmodule

// File: rtl/gate_bist_checker.sv
// Self-test sequencer for the basic-gate block: walks {a,b} through 00..11, checks y.
// Optional MISR signature output is built when GATE_BIST_SIGNATURE_EN is defined.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic       a_o,
    output logic       b_o,
    input  logic [6:0] y_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [2:0] err_count_o,
    output logic [1:0] fail_vec_o,
    output logic [6:0] fail_bits_o
`ifdef GATE_BIST_SIGNATURE_EN
    ,
    output logic [7:0] signature_o
`endif
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    logic [1:0]   state_q, state_d;
    logic [1:0]   vec_q, vec_d;
    logic [7:0]   hold_q, hold_d;
    bist_result_t res_q, res_d;
    logic [6:0]   exp_y;
    logic [6:0]   diff;
    logic         sample;

    gate_golden_model u_golden (
        .a_i (vec_q[1]),
        .b_i (vec_q[0]),
        .y_o (exp_y)
    );

    assign diff   = y_i ^ exp_y;
    assign sample = (state_q == ST_APPLY) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        hold_d  = hold_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d = ST_APPLY;
                    vec_d   = 2'd0;
                    hold_d  = 8'd0;
                    res_d   = '0;
                end
            end
            ST_APPLY: begin
                if (sample) begin
                    hold_d = 8'd0;
                    // Written as match-else so an unknown y falls into the mismatch branch
                    if (diff == 7'd0) begin
                    end else begin
                        res_d.err_count = res_q.err_count + 3'd1;
                        if (res_q.err_count == 3'd0) begin
                            res_d.fail_vec  = vec_q;
                            res_d.fail_bits = diff;
                        end
                    end
                    if (vec_q == 2'b11) state_d = ST_DONE;
                    else                vec_d   = vec_q + 2'd1;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            vec_q   <= 2'd0;
            hold_q  <= 8'd0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            hold_q  <= hold_d;
            res_q   <= res_d;
        end
    end

    assign busy_o      = (state_q == ST_APPLY);
    assign done_o      = (state_q == ST_DONE);
    assign pass_o      = done_o && (res_q.err_count == 3'd0);
    assign a_o         = busy_o & vec_q[1];
    assign b_o         = busy_o & vec_q[0];
    assign err_count_o = res_q.err_count;
    assign fail_vec_o  = res_q.fail_vec;
    assign fail_bits_o = res_q.fail_bits;

`ifdef GATE_BIST_SIGNATURE_EN
    logic [7:0] sig_q, sig_d;

    always_comb begin
        sig_d = sig_q;
        if ((state_q != ST_APPLY) && start_i) sig_d = 8'h00;
        else if (sample)                      sig_d = misr_step(sig_q, y_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sig_q <= 8'h00;
        else       sig_q <= sig_d;
    end

    assign signature_o = sig_q;
`endif

endmodule

// File: tb/tb_gate_bist_checker.sv
// Scoreboard bench for gate_bist_checker: a fault-injectable gate model feeds y,
// expectations are queued per run and checked by a monitor when done rises.
module tb_gate_bist_checker;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst, start, start1;
    logic       a, b, busy, done, pass;
    logic [2:0] errc;
    logic [1:0] fvec;
    logic [6:0] fbits, y;
    logic [7:0] sig;
    logic       a1, b1, busy1, done1, pass1;
    logic [2:0] errc1;
    logic [1:0] fvec1;
    logic [6:0] fbits1, y1;
    logic [7:0] sig1;

    int checks = 0;
    int failures = 0;

    // Fault injection: mode 1 = xor output wired as or; masks apply on top
    int         fmode = 0;
    logic [6:0] s0 = '0, s1 = '0, flip = '0;

    typedef struct {
        int         err;
        logic [1:0] fvec;
        logic [6:0] fbits;
        logic       pass;
        logic [7:0] sig;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    function automatic logic [6:0] gold(input logic ai, input logic bi);
        logic [6:0] g;
        g[0] = ai & bi;
        g[1] = ai | bi;
        g[2] = !ai;
        g[3] = !(ai & bi);
        g[4] = !(ai | bi);
        g[5] = ai ^ bi;
        g[6] = !(ai ^ bi);
        return g;
    endfunction

    function automatic logic [6:0] gate_blk(input logic ai, input logic bi, input int md,
                                            input logic [6:0] m0, input logic [6:0] m1,
                                            input logic [6:0] fl);
        logic [6:0] g;
        g = gold(ai, bi);
        if (md == 1) g[5] = ai | bi;
        return ((g & ~m0) | m1) ^ fl;
    endfunction

    function automatic exp_t predict(input int md, input logic [6:0] m0,
                                     input logic [6:0] m1, input logic [6:0] fl);
        exp_t       e;
        logic [7:0] m;
        logic [6:0] yy, d;
        logic [1:0] v;
        m = 8'h00;
        e.err = 0; e.fvec = 2'b00; e.fbits = 7'h00;
        for (int k = 0; k < 4; k++) begin
            v  = 2'(k);
            yy = gate_blk(v[1], v[0], md, m0, m1, fl);
            d  = yy ^ gold(v[1], v[0]);
            if (d != 7'h00) begin
                if (e.err == 0) begin
                    e.fvec  = v;
                    e.fbits = d;
                end
                e.err++;
            end
            m = {m[6:0], 1'b0} ^ (m[7] ? 8'h71 : 8'h00) ^ {1'b0, yy};
        end
        e.pass = (e.err == 0);
        e.sig  = m;
        return e;
    endfunction

    assign y  = gate_blk(a, b, fmode, s0, s1, flip);
    assign y1 = gold(a1, b1);

    gate_bist_checker #(.HOLD_CYCLES(H)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_o(a), .b_o(b), .y_i(y),
        .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(errc),
        .fail_vec_o(fvec), .fail_bits_o(fbits)
`ifdef GATE_BIST_SIGNATURE_EN
        , .signature_o(sig)
`endif
    );

    gate_bist_checker #(.HOLD_CYCLES(1)) u_dut_h1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .a_o(a1), .b_o(b1), .y_i(y1),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_count_o(errc1),
        .fail_vec_o(fvec1), .fail_bits_o(fbits1)
`ifdef GATE_BIST_SIGNATURE_EN
        , .signature_o(sig1)
`endif
    );

`ifndef GATE_BIST_SIGNATURE_EN
    assign sig  = 8'h00;
    assign sig1 = 8'h00;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Monitor: per-run sequencing checks and scoreboard pop on done rising
    int   cyc = 0;
    bit   ab_ok = 1'b1;
    logic busy_p = 1'b0, done_p = 1'b0;
    exp_t e_m;

    always @(negedge clk) begin
        if (rst) begin
            busy_p = 1'b0;
            done_p = 1'b0;
        end else begin
            chk("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
            if (busy) begin
                if (!busy_p) begin
                    chk("restart_err_cleared", {29'd0, errc}, 32'd0);
                    chk("restart_fbits_cleared", {25'd0, fbits}, 32'd0);
`ifdef GATE_BIST_SIGNATURE_EN
                    chk("restart_sig_seeded", {24'd0, sig}, 32'd0);
`endif
                    cyc   = 0;
                    ab_ok = 1'b1;
                end
                if ({a, b} != 2'(cyc / H)) ab_ok = 1'b0;
                cyc++;
            end
            if (done && !done_p) begin
                chk("scoreboard_has_entry", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e_m = exp_q.pop_front();
                    chk("busy_cycles", cyc, 4 * H);
                    chk("ab_sequence", {31'd0, ab_ok}, 32'd1);
                    chk("ab_zero_in_done", {30'd0, a, b}, 32'd0);
                    chk("err_count", {29'd0, errc}, e_m.err);
                    chk("fail_vec", {30'd0, fvec}, {30'd0, e_m.fvec});
                    chk("fail_bits", {25'd0, fbits}, {25'd0, e_m.fbits});
                    chk("pass", {31'd0, pass}, {31'd0, e_m.pass});
`ifdef GATE_BIST_SIGNATURE_EN
                    chk("signature", {24'd0, sig}, {24'd0, e_m.sig});
`endif
                end
            end
            busy_p = busy;
            done_p = done;
        end
    end

    task automatic run(input int md, input logic [6:0] m0, input logic [6:0] m1,
                       input logic [6:0] fl, input int hold_n);
        fmode = md; s0 = m0; s1 = m1; flip = fl;
        exp_q.push_back(predict(md, m0, m1, fl));
        @(negedge clk);
        start = 1'b1;
        repeat (hold_n) @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        chk("done_within_bound", {31'd0, done}, 32'd1);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {a, b, busy, done, pass, errc, fvec, fbits, sig}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);

        // Fault-free, then a second start from DONE must repeat identically
        run(0, 7'h00, 7'h00, 7'h00, 1);
`ifdef GATE_BIST_SIGNATURE_EN
        chk("sig_fault_free", {24'd0, sig}, 32'h000000AD);
`endif
        run(0, 7'h00, 7'h00, 7'h00, 1);
        chk("pass_fault_free", {31'd0, pass}, 32'd1);

        // not output stuck at 0
        run(0, 7'h04, 7'h00, 7'h00, 1);
        chk("not_sa0_err", {29'd0, errc}, 32'd2);
        chk("not_sa0_fbits", {25'd0, fbits}, 32'h04);
`ifdef GATE_BIST_SIGNATURE_EN
        chk("not_sa0_sig_differs", {31'd0, sig != 8'hAD}, 32'd1);
`endif

        // xor wired as or
        run(1, 7'h00, 7'h00, 7'h00, 1);
        chk("xor_as_or_vec", {30'd0, fvec}, 32'd3);
        chk("xor_as_or_fbits", {25'd0, fbits}, 32'h20);

        // start held high into APPLY must not restart the run
        run(0, 7'h00, 7'h00, 7'h00, 6);

        for (int r = 0; r < 24; r++) begin
            int         md;
            logic [6:0] m0, m1, fl;
            md = int'($urandom_range(0, 3));
            m0 = 7'($urandom & $urandom);
            m1 = 7'($urandom & $urandom & $urandom);
            fl = 7'($urandom & $urandom & $urandom);
            if (md == 0) begin m0 = '0; m1 = '0; fl = '0; end
            if (md == 3) begin m0 = '0; m1 = '0; fl = 7'(1 << $urandom_range(0, 6)); end
            run(md == 1 ? 1 : 0, m0, m1, fl, int'($urandom_range(1, 6)));
        end

        // Reset partway through a faulty run
        fmode = 0; s0 = 7'h04; s1 = '0; flip = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("reset_mid_run");
        @(negedge clk); rst = 1'b0;
        run(0, 7'h00, 7'h00, 7'h00, 1);
        chk("after_reset_pass", {31'd0, pass}, 32'd1);

        // Minimum hold: one cycle per vector
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("h1_ab", {30'd0, a1, b1}, k);
            chk("h1_busy", {31'd0, busy1}, 32'd1);
            @(negedge clk);
        end
        chk("h1_done", {31'd0, done1}, 32'd1);
        chk("h1_pass", {31'd0, pass1}, 32'd1);
        chk("h1_err", {29'd0, errc1}, 32'd0);
        chk("h1_fbits", {23'd0, fvec1, fbits1}, 32'd0);
`ifdef GATE_BIST_SIGNATURE_EN
        chk("h1_sig", {24'd0, sig1}, 32'h000000AD);
`endif

        @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_bist_checker.md
# gate_bist_checker

- Hardware self-test sequencer for the basic-gate block (AND, OR, NOT, NAND, NOR, XOR, XNOR).
- It is the response-checking counterpart of the stimulus bench:
  - drives the gate inputs `a`/`b` through all four input combinations;
  - holds each combination for a set number of cycles;
  - samples the seven gate outputs and compares them against golden values;
  - reports pass/fail, the error count and the first failing vector.
- Sits between the gate block and a status/CSR collector, so gate integrity can be checked on silicon without a simulator.

## Interface

Parameters:
- `HOLD_CYCLES`, default 4: cycles each vector is applied before sampling; legal range 1–255.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `start`  in  1  — begin a test run; sampled at a rising edge.
- `a`  out  1  — gate input A, to the DUT.
- `b`  out  1  — gate input B, to the DUT.
- `y`  in  7  — DUT outputs, packed `{xnor, xor, nor, nand, not, or, and}` (bit 6 down to bit 0).
- `busy`  out  1  — run in progress.
- `done`  out  1  — run complete; result outputs valid.
- `pass`  out  1  — all four vectors matched; valid only while `done`=1.
- `err_count`  out  3  — number of mismatching vectors, 0–4.
- `fail_vec`  out  2  — `{a,b}` of the first mismatching vector.
- `fail_bits`  out  7  — `y XOR expected` at the first mismatch.
- `signature`  out  8  — MISR signature; present only under `GATE_BIST_SIGNATURE_EN`.

## Operation

- **FSM states:** IDLE, APPLY, DONE.
- **IDLE:**
  - `a`=`b`=0.
  - `start`=1 → APPLY with vector index 0.
  - Clears `err_count`, `fail_vec`, `fail_bits`, `signature` and `pass`.
- **APPLY:**
  - `{a,b}` = vector index, in order 00, 01, 10, 11.
  - A hold counter runs 0..`HOLD_CYCLES`-1.
  - On the edge ending the last hold cycle, `y` is compared with the golden value:
    - and=a&b, or=a|b, not=~a, nand=~(a&b), nor=~(a|b), xor=a^b, xnor=~(a^b).
  - On a mismatch:
    - `err_count` increments;
    - if this is the first mismatch, `fail_vec` and `fail_bits` are latched.
  - Then the index increments, or the FSM goes to DONE after vector 11.
- **DONE:**
  - `a`=`b`=0.
  - `done`=1; `pass` = (`err_count`==0).
  - Results hold until the next `start`.
  - `start` in DONE clears the results and re-enters APPLY.
- **`start` while in APPLY:** ignored.
- **`busy`:** asserted exactly while in APPLY. `done` and `busy` are never both 1.
- **Golden-model width:** the comparison is a pure 7-bit XOR. No X-handling is required; any non-0/1 value on `y` counts as a mismatch in simulation.

## Timing

- **Reset values:** `a`=0, `b`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_vec`=0, `fail_bits`=0, `signature`=0. FSM state is IDLE.
- **Reset mid-run:** all outputs go to their reset values immediately (asynchronous). No partial results are retained.
- **Start of run:** `start` is sampled high at edge E0. `busy`=1 and `{a,b}`=00 from E0.
- **Per-vector timing:**
  - vector k is driven in cycles E0+k·H .. E0+(k+1)·H−1, where H=`HOLD_CYCLES`;
  - `y` is sampled at edge E0+(k+1)·H.
- **End of run:** `done`=1 from edge E0+4·H. Total busy time is 4·H cycles.
- **DUT settling:** `y` must be settled one cycle after `{a,b}` changes. With `HOLD_CYCLES`=1 the DUT must be purely combinational.
- **Error counter:** `err_count` updates in the same edge as the sample. It cannot overflow, since at most 4 vectors are checked.

## Configuration

- **Macro:** `GATE_BIST_SIGNATURE_EN`.
- **Defined:**
  - an 8-bit MISR, seeded to 0 at `start`, is updated at each sample edge:
    - sig ← ({sig[6:0],0} ^ (sig[7] ? 8'h71 : 0)) ^ {0,y};
  - `signature` is exported. For a fault-free DUT the final signature is 8'hAD.
- **Undefined:** no MISR logic is built and there is no `signature` port. All other behaviour is identical.

## Structure

- **Package `gate_bist_pkg`:**
  - FSM state encoding (IDLE/APPLY/DONE);
  - `y` bit-index constants;
  - MISR polynomial constant 8'h71;
  - expected fault-free signature 8'hAD.
- **Sub-module `gate_golden_model`:** combinational; maps `{a,b}` to the expected 7-bit `y`, in the same packing as the DUT.

## Test plan

- **Fault-free DUT, H=4:** pulse `start` → `busy` for 16 cycles, then `done`=1, `pass`=1, `err_count`=0. Under the macro, `signature`=8'hAD.
- **`not` output stuck-at-0 (`y[2]`=0):**
  - expect `err_count`=2, `fail_vec`=2'b00, `fail_bits`=7'h04, `pass`=0;
  - expect a `signature` different from 8'hAD (macro build).
- **`xor` driven as `or` (DUT fault):** expect `err_count`=1, `fail_vec`=2'b11, `fail_bits`=7'h20.
- **Retrigger and ignored start:** `start` held high during APPLY → no restart; `done` still occurs at 4·H. A second `start` in DONE → results clear and the run repeats identically.
- **Reset mid-run:** assert `rst` at cycle 6 of a run → all outputs are 0 immediately. After release, a new run completes normally.
- **Minimum hold, H=1:** `{a,b}` steps through 00, 01, 10, 11 on consecutive cycles; `done` at E0+4.
